// File: rtl/jtbubl_pkg.sv
// Shared jtbubl constants: palette image geometry, ROM address width, and the
// palette loader state encoding.
package jtbubl_pkg;

    localparam int PAL_AW    = 9;
    localparam int PAL_BYTES = 1 << PAL_AW;
    localparam int ROM_AW    = 22;

    // Each colour occupies two bytes: even address holds R/G, odd address holds B.
    localparam logic PAL_BYTE_RG = 1'b0;
    localparam logic PAL_BYTE_B  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_VB,
        ST_FETCH,
        ST_WRITE,
        ST_CHK_RD,
        ST_CHK_CMP,
        ST_FINISH
    } pal_ld_state_t;

endpackage

// File: rtl/jtbubl_pal_loader.sv
// Copies a palette image from ROM into palette RAM during vertical blank,
// optionally reading each byte back to flag mismatches.
module jtbubl_pal_loader
    import jtbubl_pkg::*;
#(
    parameter int AW     = PAL_AW,
    parameter int ROMAW  = ROM_AW,
    parameter bit VERIFY = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             LVBL,
    input  logic             start,
    input  logic [ROMAW-1:0] base_addr,
    output logic             rom_cs,
    output logic [ROMAW-1:0] rom_addr,
    input  logic [7:0]       rom_data,
    input  logic             rom_ok,
    output logic             pal_cs,
    output logic             cpu_rnw,
    output logic [AW-1:0]    pal_addr,
    output logic [7:0]       pal_wdata,
    input  logic [7:0]       pal_rdata,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [AW:0] LAST_CNT = {1'b0, {AW{1'b1}}};

    pal_ld_state_t    r_state;
    pal_ld_state_t    w_next;
    logic [ROMAW-1:0] r_base;
    logic [AW:0]      r_cnt;
    logic [7:0]       r_data;
    logic             r_err;
    logic             w_last;
    logic             w_byte_done;
    logic             w_advance;

    assign w_last    = (r_cnt == LAST_CNT);
    assign rom_addr  = r_base + ROMAW'(r_cnt);
    assign pal_addr  = r_cnt[AW-1:0];
    assign pal_wdata = r_data;
    assign err       = r_err;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (rst) begin
            r_state <= ST_IDLE;
            r_base  <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_base <= base_addr;
                        r_cnt  <= '0;
                        r_err  <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (rom_ok) r_data <= rom_data;
                end
                ST_CHK_CMP: begin
                    if (pal_rdata != r_data) r_err <= 1'b1;
                end
                default: ;
            endcase
            if (w_advance) r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case statement can infer a latch.
        w_next      = r_state;
        w_byte_done = 1'b0;
        w_advance   = 1'b0;
        rom_cs      = 1'b0;
        pal_cs      = 1'b0;
        cpu_rnw     = 1'b1;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_WAIT_VB;
            end
            ST_WAIT_VB: begin
                busy = 1'b1;
                if (!LVBL) w_next = ST_FETCH;
            end
            ST_FETCH: begin
                busy   = 1'b1;
                rom_cs = 1'b1;
                if (rom_ok) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                busy    = 1'b1;
                pal_cs  = 1'b1;
                cpu_rnw = 1'b0;
                if (VERIFY) w_next = ST_CHK_RD;
                else        w_byte_done = 1'b1;
            end
            ST_CHK_RD: begin
                busy   = 1'b1;
                pal_cs = 1'b1;
                w_next = ST_CHK_CMP;
            end
            ST_CHK_CMP: begin
                busy        = 1'b1;
                w_byte_done = 1'b1;
            end
            ST_FINISH: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase

        // The byte in flight always completes; blank only gates the next fetch.
        if (w_byte_done) begin
            if (w_last) begin
                w_next = ST_FINISH;
            end else begin
                w_advance = 1'b1;
                w_next    = LVBL ? ST_WAIT_VB : ST_FETCH;
            end
        end
    end

endmodule

// File: tb/tb_jtbubl_pal_loader.sv
// Scoreboard bench for jtbubl_pal_loader with ROM and palette RAM models.
module tb_jtbubl_pal_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        LVBL;
    logic        start;
    logic [21:0] base_addr;
    logic        rom_cs;
    logic [21:0] rom_addr;
    logic [7:0]  rom_data = 8'h00;
    logic        rom_ok = 1'b0;
    logic        pal_cs;
    logic        cpu_rnw;
    logic [8:0]  pal_addr;
    logic [7:0]  pal_wdata;
    logic [7:0]  pal_rdata = 8'h00;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct packed {
        logic [8:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        sb_q[$];
    wr_t        mon_e;
    int         total = 0;
    int         bad = 0;
    int         done_cnt = 0;
    logic [7:0] pal_mem [512];
    logic       corrupt_en = 1'b0;
    logic [1:0] rom_lat = 2'd0;
    logic       p_cs = 1'b0, p2_cs = 1'b0, p_rnw = 1'b1;
    logic [8:0] p_addr = '0;
    logic       p_rom_cs = 1'b0, p_rom_ok = 1'b0;
    logic [21:0] p_rom_addr = '0;

    always #5 clk = ~clk;

    jtbubl_pal_loader #(.AW(9), .ROMAW(22), .VERIFY(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .LVBL      (LVBL),
        .start     (start),
        .base_addr (base_addr),
        .rom_cs    (rom_cs),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rom_ok    (rom_ok),
        .pal_cs    (pal_cs),
        .cpu_rnw   (cpu_rnw),
        .pal_addr  (pal_addr),
        .pal_wdata (pal_wdata),
        .pal_rdata (pal_rdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    function automatic logic [7:0] rom_byte(input logic [21:0] a);
        return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic push_copy(input logic [21:0] base, input int n);
        wr_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = 9'(i);
            e.data = rom_byte(base + 22'(i));
            sb_q.push_back(e);
        end
    endtask

    task automatic pulse_start(input logic [21:0] b);
        base_addr = b;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(done), 1);
    endtask

    task automatic wait_write(input string name, input logic [8:0] a);
        int n = 0;
        while (!(pal_cs && !cpu_rnw && pal_addr == a) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(pal_cs && !cpu_rnw && pal_addr == a), 1);
    endtask

    task automatic wait_fetch(input string name, input logic [21:0] a);
        int n = 0;
        while (!(rom_cs && rom_addr == a) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(rom_cs && rom_addr == a), 1);
    endtask

    // ROM responds two cycles after rom_cs rises, one-cycle rom_ok.
    always @(posedge clk) begin
        if (rom_cs && !rom_ok) begin
            if (rom_lat == 2'd1) begin
                rom_ok   <= 1'b1;
                rom_data <= rom_byte(rom_addr);
                rom_lat  <= 2'd0;
            end else begin
                rom_lat <= rom_lat + 2'd1;
            end
        end else begin
            rom_ok  <= 1'b0;
            rom_lat <= 2'd0;
        end
    end

    // Palette RAM with registered read; can corrupt one address on write.
    always @(posedge clk) begin
        if (pal_cs) begin
            if (!cpu_rnw)
                pal_mem[pal_addr] <= (corrupt_en && pal_addr == 9'h0A3) ? ~pal_wdata : pal_wdata;
            else
                pal_rdata <= pal_mem[pal_addr];
        end
    end

    // Monitor: scoreboard for writes plus bus protocol checks.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (pal_cs && !cpu_rnw) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_write", 32'(pal_addr), 32'hFFFF_FFFF);
            end else begin
                mon_e = sb_q.pop_front();
                check("wr_addr", 32'(pal_addr), 32'(mon_e.addr));
                check("wr_data", 32'(pal_wdata), 32'(mon_e.data));
            end
        end
        if (!pal_cs) check("rnw_idle", 32'(cpu_rnw), 1);
        if (pal_cs && p_cs) begin
            check("pal_cs_pair_wr_rd", 32'({p_rnw, cpu_rnw}), 1);
            check("pal_cs_pair_addr", 32'(pal_addr), 32'(p_addr));
        end
        if (pal_cs && p_cs && p2_cs) check("pal_cs_run", 1, 0);
        if (rom_cs && p_rom_cs && !p_rom_ok) check("rom_addr_stable", 32'(rom_addr), 32'(p_rom_addr));
        p2_cs      = p_cs;
        p_cs       = pal_cs;
        p_rnw      = cpu_rnw;
        p_addr     = pal_addr;
        p_rom_cs   = rom_cs;
        p_rom_ok   = rom_ok;
        p_rom_addr = rom_addr;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int act_cnt;
        rst       = 1'b1;
        LVBL      = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_rom_cs", 32'(rom_cs), 0);
        check("rst_pal_cs", 32'(pal_cs), 0);
        check("rst_cpu_rnw", 32'(cpu_rnw), 1);
        check("rst_pal_addr", 32'(pal_addr), 0);
        check("rst_pal_wdata", 32'(pal_wdata), 0);
        check("rst_rom_addr", 32'(rom_addr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: full copy from 0x1000 inside blank
        LVBL = 1'b0;
        d0   = done_cnt;
        push_copy(22'h001000, 512);
        pulse_start(22'h001000);
        check("t1_busy", 32'(busy), 1);
        wait_done("t1_done");
        @(negedge clk);
        check("t1_done_once", 32'(done_cnt - d0), 1);
        check("t1_done_low", 32'(done), 0);
        check("t1_busy_low", 32'(busy), 0);
        check("t1_sb_empty", 32'(sb_q.size()), 0);
        check("t1_err", 32'(err), 0);
        check("t1_mem0", 32'(pal_mem[0]), 'h10);
        check("t1_mem1ff", 32'(pal_mem[511]), 'hEE);

        // 2: blank ends during byte 100, resume on next blank
        push_copy(22'h000800, 512);
        pulse_start(22'h000800);
        wait_fetch("t2_fetch100", 22'h000800 + 22'd100);
        LVBL = 1'b1;
        wait_write("t2_write100", 9'd100);
        repeat (3) @(negedge clk);
        act_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (pal_cs || rom_cs) act_cnt++;
        end
        check("t2_no_bus_outside_blank", 32'(act_cnt), 0);
        check("t2_busy_held", 32'(busy), 1);
        check("t2_cnt_preserved", 32'(pal_addr), 101);
        LVBL = 1'b0;
        wait_done("t2_done");
        @(negedge clk);
        check("t2_sb_empty", 32'(sb_q.size()), 0);

        // 3: readback mismatch at 0x0A3
        corrupt_en = 1'b1;
        push_copy(22'h002000, 512);
        pulse_start(22'h002000);
        wait_write("t3_write_a3", 9'h0A3);
        check("t3_err_before", 32'(err), 0);
        repeat (3) @(negedge clk);
        check("t3_err_set", 32'(err), 1);
        check("t3_busy_continues", 32'(busy), 1);
        wait_done("t3_done");
        @(negedge clk);
        check("t3_err_sticky", 32'(err), 1);
        check("t3_sb_empty", 32'(sb_q.size()), 0);
        corrupt_en = 1'b0;

        // 4: restart ignored while busy, then reset mid-copy
        push_copy(22'h003000, 201);
        pulse_start(22'h003000);
        check("t4_err_cleared", 32'(err), 0);
        wait_write("t4_write50", 9'd50);
        base_addr = 22'h015555;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        wait_write("t4_write200", 9'd200);
        rst = 1'b1;
        @(negedge clk);
        check("t4_rst_pal_cs", 32'(pal_cs), 0);
        check("t4_rst_busy", 32'(busy), 0);
        check("t4_rst_rom_cs", 32'(rom_cs), 0);
        check("t4_rst_rnw", 32'(cpu_rnw), 1);
        rst = 1'b0;
        @(negedge clk);
        check("t4_sb_empty", 32'(sb_q.size()), 0);
        check("t4_idle", 32'(busy), 0);

        // 5: ROM address wraps; start coinciding with done is ignored
        d0 = done_cnt;
        push_copy(22'h3FFFFC, 512);
        pulse_start(22'h3FFFFC);
        wait_fetch("t5_wrap_fetch", 22'h000000);
        check("t5_wrap_pal_addr", 32'(pal_addr), 4);
        wait_done("t5_done");
        base_addr = 22'h000100;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        act_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy) act_cnt++;
        end
        check("t5_start_at_done_ignored", 32'(act_cnt), 0);
        check("t5_done_once", 32'(done_cnt - d0), 1);
        check("t5_sb_empty", 32'(sb_q.size()), 0);
        check("t5_mem0", 32'(pal_mem[0]), 'h3C);
        check("t5_mem3", 32'(pal_mem[3]), 'h3F);
        check("t5_mem4", 32'(pal_mem[4]), 'h00);
        check("t5_mem1ff", 32'(pal_mem[511]), 'hFA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
